// File: rtl/poly_mem_pkg.sv
// Shared types and size helpers for the AMNS operand memory sequencer.
// Every derived width and length is computed here so the interface and the core agree.
package poly_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_DONE,
        STORE,
        STORE_DONE
    } state_t;

    function automatic int slot_words(input int n, input int s, input int num_in);
        return (num_in + 1) * n * s + n;
    endfunction

    function automatic int load_len(input int n, input int s, input int num_in);
        return num_in * n * s + n;
    endfunction

    // The result region sits directly behind the full operands and the short operand.
    function automatic int res_offset(input int n, input int s, input int num_in);
        return num_in * n * s + n;
    endfunction

    function automatic int sel_width(input int num_in);
        return $clog2(num_in + 1);
    endfunction

    function automatic int slot_width(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

// File: rtl/poly_memory_sequencer_if.sv
// Request handshake plus BRAM / register-file control bundle of the sequencer.
// The requester uses the master modport, the sequencer the slave modport.
interface poly_memory_sequencer_if #(
    parameter int N         = 5,
    parameter int S         = 4,
    parameter int NUM_IN    = 3,
    parameter int NUM_SLOTS = 2
);
    localparam int SLOT_W = poly_mem_pkg::slot_width(NUM_SLOTS);
    localparam int ADDR_W = $clog2(NUM_SLOTS * poly_mem_pkg::slot_words(N, S, NUM_IN));
    localparam int SEL_W  = poly_mem_pkg::sel_width(NUM_IN);

    logic              load_start_i;
    logic              store_start_i;
    logic [SLOT_W-1:0] slot_i;
    logic              BRAM_we_o;
    logic [ADDR_W-1:0] BRAM_addr_o;
    logic [SEL_W-1:0]  INPUT_reg_sel_o;
    logic              INPUT_reg_en_o;
    logic              RES_reg_shift_o;
    logic              load_done_o;
    logic              store_done_o;
    logic              busy_o;
    logic              err_o;

    modport master (
        output load_start_i, store_start_i, slot_i,
        input  BRAM_we_o, BRAM_addr_o, INPUT_reg_sel_o, INPUT_reg_en_o,
        input  RES_reg_shift_o, load_done_o, store_done_o, busy_o, err_o
    );

    modport slave (
        input  load_start_i, store_start_i, slot_i,
        output BRAM_we_o, BRAM_addr_o, INPUT_reg_sel_o, INPUT_reg_en_o,
        output RES_reg_shift_o, load_done_o, store_done_o, busy_o, err_o
    );

endinterface

// File: rtl/poly_mem_delay_line.sv
// DEPTH-stage register shift used to align register-load controls with BRAM read data.
// Also reports whether any stage still holds a nonzero value.
module poly_mem_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             nonzero
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: these stages are flops rather than RAM, so each one is cleared;
            // a surviving stage would replay a stale enable after reset.
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    always_comb begin
        nonzero = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            nonzero = nonzero | (|stage[i]);
        end
    end

endmodule

// File: rtl/poly_memory_sequencer.sv
// BRAM sequencer for the AMNS Montgomery multiplier: streams operands of one slot into
// the input registers and writes the result back, with one queued store request.
module poly_memory_sequencer
    import poly_mem_pkg::*;
#(
    parameter int WORD_WIDTH   = 17,
    parameter int N            = 5,
    parameter int S            = 4,
    parameter int NUM_IN       = 3,
    parameter int NUM_SLOTS    = 2,
    parameter int BRAM_LATENCY = 2
) (
    input logic                    clock_i,
    input logic                    reset_n_i,
    poly_memory_sequencer_if.slave bus
);

    localparam int SLOT_WORDS = slot_words(N, S, NUM_IN);
    localparam int LOAD_LEN   = load_len(N, S, NUM_IN);
    localparam int RES_OFF    = res_offset(N, S, NUM_IN);
    localparam int BLOCK      = N * S;
    localparam int ADDR_W     = $clog2(NUM_SLOTS * SLOT_WORDS);
    localparam int SEL_W      = sel_width(NUM_IN);
    localparam int SLOT_W     = slot_width(NUM_SLOTS);
    localparam int DLY_W      = SEL_W + 2;
    localparam bit PARAMS_OK  = (WORD_WIDTH > 0) && (NUM_IN >= 1) && (NUM_SLOTS >= 1) &&
                                (BRAM_LATENCY >= 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic              pending, pend_nxt;
    logic [SLOT_W-1:0] pend_slot, pslot_nxt;
    logic              err_q;

    logic [SLOT_W-1:0] slot_c;
    logic              busy, dly_any;
    logic              start_pending, load_acc, load_drop, store_acc, store_queue, store_drop;
    logic [SEL_W-1:0]  int_sel;
    logic              int_en, int_done;
    logic [DLY_W-1:0]  dly_out;

    function automatic logic [ADDR_W-1:0] base_of(input logic [SLOT_W-1:0] slot);
        return ADDR_W'(slot) * ADDR_W'(SLOT_WORDS);
    endfunction

    assign slot_c = (int'(bus.slot_i) >= NUM_SLOTS) ? SLOT_W'(NUM_SLOTS - 1) : bus.slot_i;
    assign busy   = (state != IDLE) || dly_any;

    // A queued store owns the first idle cycle; loads are never queued.
    assign start_pending = !busy && pending;
    assign load_acc      = bus.load_start_i && !busy && !pending;
    assign load_drop     = bus.load_start_i && !load_acc;
    assign store_acc     = bus.store_start_i && !busy && !pending && !bus.load_start_i;
    assign store_queue   = bus.store_start_i && !pending && (busy || bus.load_start_i);
    assign store_drop    = bus.store_start_i && pending;

    always_comb begin
        // NOTE: every variable gets its default before the case so no path infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        base_nxt  = base;
        pend_nxt  = pending;
        pslot_nxt = pend_slot;
        int_sel   = '0;
        int_en    = 1'b0;
        int_done  = 1'b0;

        if (store_queue) begin
            pend_nxt  = 1'b1;
            pslot_nxt = slot_c;
        end

        unique case (state)
            IDLE: begin
                if (start_pending) begin
                    state_nxt = STORE;
                    cnt_nxt   = ADDR_W'(RES_OFF);
                    base_nxt  = base_of(pend_slot);
                    pend_nxt  = 1'b0;
                end else if (load_acc) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                    base_nxt  = base_of(slot_c);
                end else if (store_acc) begin
                    state_nxt = STORE;
                    cnt_nxt   = ADDR_W'(RES_OFF);
                    base_nxt  = base_of(slot_c);
                end
            end
            LOAD: begin
                int_en = 1'b1;
                for (int k = 1; k <= NUM_IN; k++) begin
                    if (cnt >= ADDR_W'(k * BLOCK)) int_sel = SEL_W'(k);
                end
                if (cnt == ADDR_W'(LOAD_LEN - 1)) begin
                    state_nxt = LOAD_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            LOAD_DONE: begin
                int_done  = 1'b1;
                state_nxt = IDLE;
            end
            STORE: begin
                if (cnt == ADDR_W'(SLOT_WORDS - 1)) begin
                    state_nxt = STORE_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            STORE_DONE: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            pending   <= 1'b0;
            pend_slot <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            base      <= base_nxt;
            pending   <= pend_nxt;
            pend_slot <= pslot_nxt;
            err_q     <= load_drop | store_drop;
        end
    end

    poly_mem_delay_line #(
        .DEPTH (BRAM_LATENCY),
        .WIDTH (DLY_W)
    ) u_dly (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .din       ({int_sel, int_en, int_done}),
        .dout      (dly_out),
        .nonzero   (dly_any)
    );

    assign bus.BRAM_we_o       = (state == STORE);
    assign bus.RES_reg_shift_o = (state == STORE);
    assign bus.BRAM_addr_o     = (state == LOAD || state == STORE) ? base + cnt : '0;
    assign {bus.INPUT_reg_sel_o, bus.INPUT_reg_en_o, bus.load_done_o} = dly_out;
    assign bus.store_done_o    = (state == STORE_DONE);
    assign bus.busy_o          = busy;
    assign bus.err_o           = err_q;

    param_check: assert property (@(posedge clock_i) PARAMS_OK);

endmodule

// File: tb/tb_poly_memory_sequencer.sv
// Scoreboard bench for poly_memory_sequencer: a default instance and a small one with
// BRAM_LATENCY=4, NUM_IN=1, N=3, S=2 share clock and reset.
module tb_poly_memory_sequencer;

    typedef enum int {EV_LD, EV_ST, EV_LDONE, EV_SDONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       sel;
        int       addr;
    } ev_t;

    logic clock;
    logic reset_n;

    poly_memory_sequencer_if #(.N(5), .S(4), .NUM_IN(3), .NUM_SLOTS(2)) bus0 ();
    poly_memory_sequencer_if #(.N(3), .S(2), .NUM_IN(1), .NUM_SLOTS(2)) bus1 ();

    poly_memory_sequencer #(
        .WORD_WIDTH(17), .N(5), .S(4), .NUM_IN(3), .NUM_SLOTS(2), .BRAM_LATENCY(2)
    ) dut0 (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .bus       (bus0)
    );

    poly_memory_sequencer #(
        .WORD_WIDTH(17), .N(3), .S(2), .NUM_IN(1), .NUM_SLOTS(2), .BRAM_LATENCY(4)
    ) dut1 (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .bus       (bus1)
    );

    int   errors = 0;
    int   checks = 0;
    ev_t  exp_q[2][$];
    int   err_exp[2] = '{0, 0};
    bit   mon_on[2]  = '{1, 1};
    logic prev_en[2] = '{0, 0};
    logic prev_we[2] = '{0, 0};
    int   hist[2][8];
    int   lat[2]     = '{2, 4};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cmp_ev(input int d, input ev_kind_t kind, input int sel, input int addr);
        ev_t e;
        checks++;
        if (exp_q[d].size() == 0) begin
            errors++;
            $display("FAIL dut%0d event: got %s sel=%0d addr=%0d, required nothing",
                     d, kind.name(), sel, addr);
        end else begin
            e = exp_q[d].pop_front();
            if (e.kind != kind || e.sel != sel || e.addr != addr) begin
                errors++;
                $display("FAIL dut%0d event: got %s sel=%0d addr=%0d, required %s sel=%0d addr=%0d",
                         d, kind.name(), sel, addr, e.kind.name(), e.sel, e.addr);
            end
        end
    endtask

    task automatic mon(input int d, input logic we, input int addr, input int sel,
                       input logic en, input logic shift, input logic ld, input logic sd,
                       input logic er);
        for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = addr;
        if (mon_on[d]) begin
            // A load beat carries the address issued BRAM-latency cycles earlier.
            if (en) cmp_ev(d, EV_LD, sel, hist[d][lat[d]]);
            if (we) begin
                check_int($sformatf("dut%0d shift with we", d), int'(shift), 1);
                cmp_ev(d, EV_ST, 0, addr);
            end
            if (ld) begin
                check_int($sformatf("dut%0d load_done after last en", d), int'(prev_en[d]), 1);
                cmp_ev(d, EV_LDONE, 0, 0);
            end
            if (sd) begin
                check_int($sformatf("dut%0d store_done after last we", d), int'(prev_we[d]), 1);
                cmp_ev(d, EV_SDONE, 0, 0);
            end
            if (er) begin
                check_int($sformatf("dut%0d err pulse expected", d), int'(err_exp[d] > 0), 1);
                if (err_exp[d] > 0) err_exp[d]--;
            end
        end
        prev_en[d] = en;
        prev_we[d] = we;
    endtask

    always @(negedge clock) begin
        mon(0, bus0.BRAM_we_o, int'(bus0.BRAM_addr_o), int'(bus0.INPUT_reg_sel_o),
            bus0.INPUT_reg_en_o, bus0.RES_reg_shift_o, bus0.load_done_o, bus0.store_done_o,
            bus0.err_o);
        mon(1, bus1.BRAM_we_o, int'(bus1.BRAM_addr_o), int'(bus1.INPUT_reg_sel_o),
            bus1.INPUT_reg_en_o, bus1.RES_reg_shift_o, bus1.load_done_o, bus1.store_done_o,
            bus1.err_o);
    end

    function automatic int out_word(input int d);
        if (d == 0)
            return int'({bus0.BRAM_we_o, bus0.RES_reg_shift_o, bus0.INPUT_reg_en_o,
                         bus0.load_done_o, bus0.store_done_o, bus0.busy_o, bus0.err_o,
                         bus0.INPUT_reg_sel_o, bus0.BRAM_addr_o});
        return int'({bus1.BRAM_we_o, bus1.RES_reg_shift_o, bus1.INPUT_reg_en_o,
                     bus1.load_done_o, bus1.store_done_o, bus1.busy_o, bus1.err_o,
                     bus1.INPUT_reg_sel_o, bus1.BRAM_addr_o});
    endfunction

    // which: 0 load_done, 1 busy, 2 store_done, 3 we, 4 input enable
    function automatic logic sig(input int d, input int which);
        case (which)
            0:       return d == 0 ? bus0.load_done_o    : bus1.load_done_o;
            1:       return d == 0 ? bus0.busy_o         : bus1.busy_o;
            2:       return d == 0 ? bus0.store_done_o   : bus1.store_done_o;
            3:       return d == 0 ? bus0.BRAM_we_o      : bus1.BRAM_we_o;
            default: return d == 0 ? bus0.INPUT_reg_en_o : bus1.INPUT_reg_en_o;
        endcase
    endfunction

    function automatic int addr_of(input int d);
        return d == 0 ? int'(bus0.BRAM_addr_o) : int'(bus1.BRAM_addr_o);
    endfunction

    task automatic wait_for(input int d, input int which, input logic val, input int budget,
                            input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clock);
            if (sig(d, which) == val) hit = 1'b1;
        end
        check_int(name, int'(hit), 1);
    endtask

    task automatic pulse(input int d, input bit ld, input bit st, input int slot);
        @(posedge clock);
        #1;
        if (d == 0) begin
            bus0.load_start_i  = ld;
            bus0.store_start_i = st;
            bus0.slot_i        = 1'(slot);
        end else begin
            bus1.load_start_i  = ld;
            bus1.store_start_i = st;
            bus1.slot_i        = 1'(slot);
        end
        @(posedge clock);
        #1;
        if (d == 0) begin
            bus0.load_start_i  = 1'b0;
            bus0.store_start_i = 1'b0;
        end else begin
            bus1.load_start_i  = 1'b0;
            bus1.store_start_i = 1'b0;
        end
    endtask

    task automatic push_load(input int d, input int slot, input int n, input int s,
                             input int ni);
        int sw  = (ni + 1) * n * s + n;
        int len = ni * n * s + n;
        ev_t e;
        for (int i = 0; i < len; i++) begin
            e.kind = EV_LD;
            e.sel  = (i < ni * n * s) ? i / (n * s) : ni;
            e.addr = slot * sw + i;
            exp_q[d].push_back(e);
        end
        e.kind = EV_LDONE; e.sel = 0; e.addr = 0;
        exp_q[d].push_back(e);
    endtask

    task automatic push_store(input int d, input int slot, input int n, input int s,
                              input int ni);
        int sw = (ni + 1) * n * s + n;
        ev_t e;
        for (int i = 0; i < n * s; i++) begin
            e.kind = EV_ST;
            e.sel  = 0;
            e.addr = slot * sw + ni * n * s + n + i;
            exp_q[d].push_back(e);
        end
        e.kind = EV_SDONE; e.sel = 0; e.addr = 0;
        exp_q[d].push_back(e);
    endtask

    initial begin
        int n_ld;
        int n_en;
        int lat_cnt;
        bit hit;

        reset_n            = 1'b0;
        bus0.load_start_i  = 1'b0;
        bus0.store_start_i = 1'b0;
        bus0.slot_i        = '0;
        bus1.load_start_i  = 1'b0;
        bus1.store_start_i = 1'b0;
        bus1.slot_i        = '0;

        #2;
        check_int("dut0 outputs in reset", out_word(0), 0);
        check_int("dut1 outputs in reset", out_word(1), 0);
        @(negedge clock);
        #2 reset_n = 1'b1;

        // Plain load of slot 0: addresses 0..64, sel 0/1/2/3.
        push_load(0, 0, 5, 4, 3);
        pulse(0, 1'b1, 1'b0, 0);
        check_int("dut0 first load addr", addr_of(0), 0);
        check_int("dut0 busy in load", int'(bus0.busy_o), 1);
        wait_for(0, 0, 1'b1, 200, "dut0 load_done seen");
        check_int("dut0 busy with load_done", int'(bus0.busy_o), 1);
        @(negedge clock);
        check_int("dut0 busy after load_done", int'(bus0.busy_o), 0);

        // Store of slot 1: addresses 150..169.
        push_store(0, 1, 5, 4, 3);
        pulse(0, 1'b0, 1'b1, 1);
        check_int("dut0 first store addr", addr_of(0), 150);
        check_int("dut0 we in store", int'(bus0.BRAM_we_o), 1);
        wait_for(0, 2, 1'b1, 100, "dut0 store_done seen");
        wait_for(0, 1, 1'b0, 10, "dut0 idle after store");

        // Load and store together on slot 1: load wins, store follows busy dropping.
        push_load(0, 1, 5, 4, 3);
        push_store(0, 1, 5, 4, 3);
        pulse(0, 1'b1, 1'b1, 1);
        check_int("dut0 slot1 first load addr", addr_of(0), 85);
        wait_for(0, 1, 1'b0, 300, "dut0 busy drops after load");
        check_int("dut0 no we while busy drops", int'(bus0.BRAM_we_o), 0);
        @(negedge clock);
        check_int("dut0 queued store starts", int'(bus0.BRAM_we_o), 1);
        check_int("dut0 queued store addr", addr_of(0), 150);
        wait_for(0, 2, 1'b1, 100, "dut0 queued store_done");
        wait_for(0, 1, 1'b0, 10, "dut0 idle after queued store");

        // Misuse during a load: second load dropped, first store queued, second dropped.
        push_load(0, 0, 5, 4, 3);
        push_store(0, 1, 5, 4, 3);
        err_exp[0] += 2;
        pulse(0, 1'b1, 1'b0, 0);
        repeat (10) @(posedge clock);
        pulse(0, 1'b1, 1'b0, 1);
        pulse(0, 1'b0, 1'b1, 1);
        pulse(0, 1'b0, 1'b1, 0);
        wait_for(0, 2, 1'b1, 300, "dut0 store after misuse");
        wait_for(0, 1, 1'b0, 10, "dut0 idle after misuse");
        check_int("dut0 err pulses consumed", err_exp[0], 0);

        // Reset in the middle of a load.
        mon_on[0] = 1'b0;
        pulse(0, 1'b1, 1'b0, 0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clock);
            if (addr_of(0) == 30) hit = 1'b1;
        end
        check_int("dut0 reached addr 30", int'(hit), 1);
        #1 reset_n = 1'b0;
        #1;
        check_int("dut0 outputs async reset", out_word(0), 0);
        check_int("dut1 outputs async reset", out_word(1), 0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        n_ld = 0;
        n_en = 0;
        repeat (80) begin
            @(negedge clock);
            if (bus0.load_done_o) n_ld++;
            if (bus0.INPUT_reg_en_o) n_en++;
        end
        check_int("dut0 no load_done after reset", n_ld, 0);
        check_int("dut0 no enables after reset", n_en, 0);
        check_int("dut0 idle after reset", int'(bus0.busy_o), 0);
        mon_on[0] = 1'b1;
        push_load(0, 0, 5, 4, 3);
        pulse(0, 1'b1, 1'b0, 0);
        check_int("dut0 restart addr", addr_of(0), 0);
        wait_for(0, 0, 1'b1, 200, "dut0 restart load_done");
        wait_for(0, 1, 1'b0, 10, "dut0 idle after restart");

        // Small configuration with latency 4.
        push_load(1, 0, 3, 2, 1);
        pulse(1, 1'b1, 1'b0, 0);
        check_int("dut1 first load addr", addr_of(1), 0);
        lat_cnt = 0;
        while (lat_cnt < 20 && !bus1.INPUT_reg_en_o) begin
            @(negedge clock);
            lat_cnt++;
        end
        check_int("dut1 enable latency", lat_cnt, 5);
        wait_for(1, 0, 1'b1, 50, "dut1 load_done seen");
        wait_for(1, 1, 1'b0, 10, "dut1 idle after load");
        push_store(1, 0, 3, 2, 1);
        pulse(1, 1'b0, 1'b1, 0);
        check_int("dut1 first store addr", addr_of(1), 9);
        wait_for(1, 2, 1'b1, 50, "dut1 store_done seen");
        wait_for(1, 1, 1'b0, 10, "dut1 idle after store");

        repeat (3) @(negedge clock);
        check_int("dut0 expected events left", exp_q[0].size(), 0);
        check_int("dut1 expected events left", exp_q[1].size(), 0);
        check_int("dut0 expected err left", err_exp[0], 0);
        check_int("dut1 expected err left", err_exp[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
